// File: rtl/grey_pkg.sv
// Ring-grey digit code table and conversion helpers shared by the digit counter
// and the 7-segment decoder stage.
package grey_pkg;

    localparam logic [4:0] G_ZERO  = 5'b10001;
    localparam logic [4:0] G_ONE   = 5'b00001;
    localparam logic [4:0] G_TWO   = 5'b00011;
    localparam logic [4:0] G_THREE = 5'b00010;
    localparam logic [4:0] G_FOUR  = 5'b00110;
    localparam logic [4:0] G_FIVE  = 5'b00100;
    localparam logic [4:0] G_SIX   = 5'b01100;
    localparam logic [4:0] G_SEVEN = 5'b01000;
    localparam logic [4:0] G_EIGHT = 5'b11000;
    localparam logic [4:0] G_NINE  = 5'b10000;
    localparam logic [4:0] G_DP    = 5'b10101;

    function automatic logic [4:0] f_digit2grey(input logic [3:0] digit);
        case (digit)
            4'd0:    return G_ZERO;
            4'd1:    return G_ONE;
            4'd2:    return G_TWO;
            4'd3:    return G_THREE;
            4'd4:    return G_FOUR;
            4'd5:    return G_FIVE;
            4'd6:    return G_SIX;
            4'd7:    return G_SEVEN;
            4'd8:    return G_EIGHT;
            4'd9:    return G_NINE;
            default: return G_ZERO;
        endcase
    endfunction

    function automatic logic [3:0] f_grey2digit(input logic [4:0] code);
        case (code)
            G_ONE:   return 4'd1;
            G_TWO:   return 4'd2;
            G_THREE: return 4'd3;
            G_FOUR:  return 4'd4;
            G_FIVE:  return 4'd5;
            G_SIX:   return 4'd6;
            G_SEVEN: return 4'd7;
            G_EIGHT: return 4'd8;
            G_NINE:  return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic f_grey_legal(input logic [4:0] code);
        case (code)
            G_ZERO, G_ONE, G_TWO, G_THREE, G_FOUR,
            G_FIVE, G_SIX, G_SEVEN, G_EIGHT, G_NINE: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    // Neighbour in the ring: walks the code table so each move flips one bit.
    function automatic logic [4:0] f_grey_step(input logic [4:0] code, input logic up);
        case (code)
            G_ZERO:  return up ? G_ONE   : G_NINE;
            G_ONE:   return up ? G_TWO   : G_ZERO;
            G_TWO:   return up ? G_THREE : G_ONE;
            G_THREE: return up ? G_FOUR  : G_TWO;
            G_FOUR:  return up ? G_FIVE  : G_THREE;
            G_FIVE:  return up ? G_SIX   : G_FOUR;
            G_SIX:   return up ? G_SEVEN : G_FIVE;
            G_SEVEN: return up ? G_EIGHT : G_SIX;
            G_EIGHT: return up ? G_NINE  : G_SEVEN;
            G_NINE:  return up ? G_ZERO  : G_EIGHT;
            default: return G_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/grey_digit_counter_tick_divider.sv
// Prescaler: emits one step per P_DIV enabled cycles; holds while disabled.
module tick_divider #(
    parameter int P_DIV  = 4,
    parameter int P_DIVW = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_step
);

    localparam logic [P_DIVW-1:0] LAST = P_DIVW'(P_DIV - 1);

    logic [P_DIVW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + P_DIVW'(1);
    end

    // With P_DIV=1 the counter never leaves 0, so the step follows the enable.
    assign o_step = i_en && (r_cnt == LAST);

endmodule

// File: rtl/grey_digit_counter.sv
// Single decimal digit held in ring-grey code, stepped up/down by a prescaled
// enable, with parallel load, illegal-code recovery and a decimal-point override.
module grey_digit_counter
    import grey_pkg::*;
#(
    parameter int P_DIV  = 4,
    parameter int P_DIVW = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [3:0] i_load_digit,
    input  logic       i_dp,
    output logic [4:0] o_grey,
    output logic [3:0] o_digit,
    output logic       o_wrap,
    output logic       o_err
);

    logic [4:0] r_code, code_nxt;
    logic       r_dp, r_wrap, r_err;
    logic       wrap_nxt, err_nxt;
    logic       step;

    tick_divider #(
        .P_DIV  (P_DIV),
        .P_DIVW (P_DIVW)
    ) u_div (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_clr  (i_load),
        .o_step (step)
    );

    // Load beats recovery and step; an illegal code recovers before any step.
    always_comb begin
        code_nxt = r_code;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
        if (i_load) begin
            code_nxt = f_digit2grey(i_load_digit);
            err_nxt  = (i_load_digit > 4'd9);
        end else if (!f_grey_legal(r_code)) begin
            code_nxt = G_ZERO;
            err_nxt  = 1'b1;
        end else if (step) begin
            code_nxt = f_grey_step(r_code, i_up);
            wrap_nxt = i_up ? (r_code == G_NINE) : (r_code == G_ZERO);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_code <= G_ZERO;
            r_dp   <= 1'b0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_code <= code_nxt;
            r_dp   <= i_dp;
            r_wrap <= wrap_nxt;
            r_err  <= err_nxt;
        end
    end

    assign o_grey  = r_dp ? G_DP : r_code;
    assign o_digit = f_grey2digit(r_code);
    assign o_wrap  = r_wrap;
    assign o_err   = r_err;

endmodule

// File: doc/grey_digit_counter.md
# grey_digit_counter

Upstream source for the 7-segment LED decoder stage. Holds one decimal digit (0–9) directly in the team's 5-bit ring-grey code, where adjacent digits differ in exactly one bit. Advances the digit up or down on a prescaled enable, supports parallel load and a decimal-point override, and flags wrap-around and bad loads. `o_grey` connects unmodified to the decoder's `i_grey` input.

## Interface
Parameters:
- `P_DIV`, default 4: number of enabled clock cycles per count step; legal range 1..65535.
- `P_DIVW`, default 16: width of the prescaler counter; must hold `P_DIV-1`.

Ports:
- `i_clk`, input, 1: clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_en`, input, 1: count enable; the prescaler advances only while high.
- `i_up`, input, 1: direction; 1 = up, 0 = down; sampled on the step cycle.
- `i_load`, input, 1: parallel load strobe.
- `i_load_digit`, input, 4: binary digit to load.
- `i_dp`, input, 1: decimal-point request; replaces the displayed code, does not alter the count.
- `o_grey`, output, 5: grey code to the LED decoder.
- `o_digit`, output, 4: binary equivalent of the current count.
- `o_wrap`, output, 1: one-cycle pulse on a 9→0 or 0→9 step.
- `o_err`, output, 1: one-cycle pulse when a load value exceeds 9.

## Operation
- Grey codes: ZERO 10001, ONE 00001, TWO 00011, THREE 00010, FOUR 00110, FIVE 00100, SIX 01100, SEVEN 01000, EIGHT 11000, NINE 10000, DP 10101.
- Up sequence: ZERO→ONE→…→NINE→ZERO.
- Down sequence: the exact reverse of the up sequence.
- State register `r_code` (5 bits) stores the grey code itself.
- Next state comes from the code table, not from binary increment.
- Prescaler `r_cnt`:
  - While `i_en`=1, increments each cycle.
  - When `r_cnt == P_DIV-1` and `i_en`=1, asserts internal `step` and returns to 0.
  - While `i_en`=0, holds its value.
  - With `P_DIV=1`, `step` equals `i_en`.
- On `step`: `r_code` moves one position in the direction given by `i_up`.
  - NINE→ZERO (up) or ZERO→NINE (down) sets `o_wrap`=1 on the next cycle.
- Load:
  - `i_load`=1 sets `r_code` to the code for `i_load_digit` and clears `r_cnt` to 0.
  - If `i_load_digit` > 9: `r_code` becomes ZERO and `o_err` pulses.
- Priority, highest first: `i_rst`, `i_load`, `step`.
  - When load and step coincide: the load wins, the step is discarded, and there is no `o_wrap`.
- Illegal state recovery: if `r_code` holds a non-table value, the next cycle forces ZERO and pulses `o_err`.
- `o_digit`: combinational decode of `r_code`; reads 0 for an illegal code.
- Decimal point: `r_dp` is `i_dp` registered. `o_grey` = `r_dp` ? DP : `r_code`.
- `i_up` and `i_dp` may change on any cycle.

## Timing
- Reset values: `r_code`=ZERO, so `o_grey`=10001 and `o_digit`=0. `r_cnt`=0, `r_dp`=0, `o_wrap`=0, `o_err`=0.
- Reset asserted mid-count returns every register to its reset value on the next edge, regardless of `i_load` or `i_en`.
- Step latency: `i_en` high from cycle 0 with `r_cnt`=0 gives a new `o_grey` after edge `P_DIV-1`. It is visible in cycle `P_DIV`.
- Load latency: 1 cycle.
- `o_wrap` and `o_err`: asserted in the same cycle as the new `r_code`, high for exactly 1 cycle.
- `i_dp` to `o_grey` latency: 1 cycle. Dropping `i_dp` restores the current count code 1 cycle later.
- Every output is registered or decoded directly from registers; there is no input-to-output combinational path.

## Structure
- Package `grey_pkg` holds:
  - the 11 code constants (ZERO..NINE, DP);
  - function `f_digit2grey` (4→5 bits, out of range maps to ZERO);
  - function `f_grey2digit` (5→4 bits, illegal maps to 0);
  - function `f_grey_legal`.
- The LED decoder stage should import the same package.
- Sub-module `tick_divider` (parameters `P_DIV`, `P_DIVW`; ports `i_clk`, `i_rst`, `i_en`, `i_clr`, `o_step`) contains the prescaler.
- The top level contains the code state machine, load/priority logic, flags, and the DP mux.

## Test plan
- Reset, then `P_DIV`=4 with `i_en`=1, `i_up`=1 for 40 cycles → `o_grey` steps every 4 cycles through 10001, 00001, 00011, …, 10000, 10001. `o_wrap` pulses once, on the 10000→10001 step.
- Check one-bit-change between successive `o_grey` values on every step of that run, with `o_digit` tracking 0..9.
- `i_up`=0 from ZERO → next step gives NINE (10000) and `o_wrap`=1; the following step gives EIGHT (11000).
- `i_load`=1 with `i_load_digit`=7 → next cycle `o_grey`=01000, `o_digit`=7, `r_cnt`=0. Then `i_load_digit`=12 → `o_grey`=10001 with a single-cycle `o_err`. Load coinciding with a step → the loaded value wins and there is no `o_wrap`.
- `i_dp`=1 for 3 cycles while counting → `o_grey`=10101 for those 3 cycles, lagging `i_dp` by 1. `o_digit` keeps counting, and the count code reappears 1 cycle after `i_dp` falls.
- `i_rst`=1 mid-count at digit 6 with `i_load`=1 → next cycle `o_grey`=10001, all flags 0, and the prescaler restarts so the first step comes after `P_DIV` enabled cycles.
- Force `r_code`=11111 → next cycle `o_grey`=10001 with an `o_err` pulse.
